// File: rtl/mbssoc_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mbssoc_uart_tx
// Description : UART transmitter fed by the bus controller's UART write strobe.
//               Bytes are queued in a FIFO and sent as 8N1 frames.
// Revision    : 1.0 - initial release
// ============================================================================
module mbssoc_uart_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 434,
    parameter int FIFO_AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ovf_clr,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  fifo_full,
    output logic [FIFO_AW:0]      fifo_count,
    output logic                  overflow
);

    localparam int              c_DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] c_DEPTH_V  = (FIFO_AW + 1)'(c_DEPTH);
    localparam logic [15:0]     c_BAUD_LAST = 16'(CLK_DIV - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_baud;
    logic [15:0] w_baud_nxt;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_tx;
    logic        w_tx_nxt;

    logic       w_baud_end;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic [7:0] w_head;

    generate
        if (DATA_WIDTH > 8) begin : g_unused_upper
            logic w_unused_upper;
            assign w_unused_upper = ^wdata[DATA_WIDTH-1:8];
        end
    endgenerate

    // A pop at the same edge frees a slot, so a full FIFO still accepts the write.
    assign w_baud_end = (r_baud == c_BAUD_LAST);
    assign w_pop      = (r_count != '0) &&
                        ((r_state == c_IDLE) || ((r_state == c_STOP) && w_baud_end));
    assign w_push     = uart_we && ((r_count != c_DEPTH_V) || w_pop);
    assign w_drop     = uart_we && !w_push;
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)       r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
        end
    end

    // State register, together with the registered serial datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (r_count != '0) w_state_nxt = c_START;
            c_START: if (w_baud_end) w_state_nxt = c_DATA;
            c_DATA:  if (w_baud_end && (r_bit == 3'd7)) w_state_nxt = c_STOP;
            c_STOP:  if (w_baud_end) w_state_nxt = (r_count != '0) ? c_START : c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_tx_nxt    = r_tx;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_baud_nxt  = (r_state == c_IDLE || w_baud_end) ? 16'd0 : r_baud + 16'd1;
        case (r_state)
            c_IDLE: begin
                if (w_pop) begin
                    w_shift_nxt = w_head;
                    w_tx_nxt    = 1'b0;
                end
            end
            c_START: begin
                if (w_baud_end) begin
                    w_tx_nxt  = r_shift[0];
                    w_bit_nxt = 3'd0;
                end
            end
            c_DATA: begin
                if (w_baud_end) begin
                    if (r_bit == 3'd7) begin
                        w_tx_nxt = 1'b1;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                        w_bit_nxt   = r_bit + 3'd1;
                    end
                end
            end
            c_STOP: begin
                // Back-to-back frames: the next start bit follows the stop bit directly.
                if (w_pop) begin
                    w_shift_nxt = w_head;
                    w_tx_nxt    = 1'b0;
                end
            end
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign tx         = r_tx;
    assign tx_busy    = (r_state != c_IDLE) || (r_count != '0);
    assign fifo_full  = (r_count == c_DEPTH_V);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mbssoc_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbssoc_uart_tx
// Description : Directed bench for mbssoc_uart_tx with a serial-line monitor
//               that decodes frames and checks them against a byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mbssoc_uart_tx;

    localparam int c_DW  = 32;
    localparam int c_DIV = 4;
    localparam int c_AW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            uart_we;
    logic [c_DW-1:0] wdata;
    logic            ovf_clr;
    logic            tx;
    logic            tx_busy;
    logic            fifo_full;
    logic [c_AW:0]   fifo_count;
    logic            overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];

    int         m_phase  = 0;
    int         m_cnt    = 0;
    logic       m_bit    = 1'b1;
    logic [7:0] m_byte   = '0;
    int         m_frames = 0;

    mbssoc_uart_tx #(
        .DATA_WIDTH(c_DW),
        .CLK_DIV   (c_DIV),
        .FIFO_AW   (c_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_we   (uart_we),
        .wdata     (wdata),
        .ovf_clr   (ovf_clr),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial decoder: every cell must hold one value for exactly c_DIV samples.
    always @(negedge clk) begin
        if (m_phase == 0) begin
            if (tx === 1'b0) begin
                m_phase = 1;
                m_cnt   = 1;
                m_bit   = 1'b0;
            end
        end else begin
            if (m_cnt == 0) begin
                m_bit = tx;
                if (m_phase >= 2 && m_phase <= 9) m_byte[m_phase-2] = tx;
                if (m_phase == 10) chk("stop_bit", {31'd0, tx}, 32'd1);
            end else begin
                chk("bit_hold", {31'd0, tx}, {31'd0, m_bit});
            end
            m_cnt++;
            if (m_cnt == c_DIV) begin
                m_cnt = 0;
                m_phase++;
                if (m_phase == 11) begin
                    m_phase = 0;
                    m_frames++;
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_frame", {24'd0, m_byte}, 32'hFFFF_FFFF);
                    end else begin
                        chk("frame_byte", {24'd0, m_byte}, {24'd0, sb.pop_front()});
                    end
                end
            end
        end
    end

    task automatic put(input logic [31:0] d, input bit accept);
        @(negedge clk);
        uart_we = 1'b1;
        wdata   = d;
        if (accept) sb.push_back(d[7:0]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_busy !== 1'b0 && n < 5000);
        chk(tag, {31'd0, (n < 5000)}, 32'd1);
    endtask

    initial begin
        int n;
        int fr;
        rst = 1'b1; uart_we = 1'b0; wdata = '0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_count", {27'd0, fifo_count}, 32'd0);
        chk("rst_full", {31'd0, fifo_full}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;

        // Single byte: latency of one edge, busy for 40 clocks.
        put(32'h0000_0055, 1'b1);
        @(negedge clk); uart_we = 1'b0;
        chk("single_count_after_push", {27'd0, fifo_count}, 32'd1);
        chk("single_tx_still_high", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("single_tx_start", {31'd0, tx}, 32'd0);
        chk("single_count_after_pop", {27'd0, fifo_count}, 32'd0);
        chk("single_busy", {31'd0, tx_busy}, 32'd1);
        n = 0;
        while (tx_busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("single_busy_len", n, 32'd40);
        chk("single_frames", m_frames, 32'd1);

        // Upper write-data bits must not reach the line.
        put(32'hABCD_EF12, 1'b1);
        @(negedge clk); uart_we = 1'b0;
        wait_idle("mask_idle");
        chk("mask_frames", m_frames, 32'd2);

        // Back-to-back frames with no idle gap.
        put(32'h0000_00A5, 1'b1);
        put(32'h0000_003C, 1'b1);
        chk("b2b_count_1", {27'd0, fifo_count}, 32'd1);
        @(negedge clk); uart_we = 1'b0;
        chk("b2b_count_2", {27'd0, fifo_count}, 32'd1);
        n = 0;
        while (fifo_count !== '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second_pop_delay", n, 32'd40);
        chk("b2b_second_start_low", {31'd0, tx}, 32'd0);
        n = 0;
        while (tx_busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second_len", n, 32'd40);
        chk("b2b_frames", m_frames, 32'd4);

        // Overflow: 18 consecutive writes, the last one is dropped.
        for (int i = 0; i < 18; i++) put(i, (i < 17));
        @(negedge clk); uart_we = 1'b0;
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_full", {31'd0, fifo_full}, 32'd1);
        chk("ovf_count", {27'd0, fifo_count}, 32'd16);
        ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Drop and clear on the same edge: set wins.
        chk("setwin_still_full", {31'd0, fifo_full}, 32'd1);
        uart_we = 1'b1; wdata = 32'h0000_00EE; ovf_clr = 1'b1;
        @(negedge clk); uart_we = 1'b0; ovf_clr = 1'b0;
        chk("setwin_ovf", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        chk("setwin_cleared", {31'd0, overflow}, 32'd0);
        wait_idle("ovf_drain_idle");
        chk("ovf_frames", m_frames, 32'd21);
        chk("ovf_sb_empty", sb.size(), 32'd0);

        // Reset in the middle of data bit 3 with 5 bytes still queued.
        for (int i = 0; i < 6; i++) put(32'h0000_00C0 + i, 1'b1);
        @(negedge clk); uart_we = 1'b0;
        chk("rstmid_count", {27'd0, fifo_count}, 32'd5);
        n = 0;
        while (m_phase != 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_reach_bit3", {31'd0, (n < 200)}, 32'd1);
        fr = m_frames;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_phase = 0;
        sb.delete();
        @(negedge clk);
        chk("rstmid_tx", {31'd0, tx}, 32'd1);
        chk("rstmid_count_zero", {27'd0, fifo_count}, 32'd0);
        chk("rstmid_busy", {31'd0, tx_busy}, 32'd0);
        repeat (60) @(negedge clk);
        chk("rstmid_no_frames", m_frames, fr);
        chk("rstmid_line_idle", {31'd0, tx}, 32'd1);

        put(32'h0000_0081, 1'b1);
        @(negedge clk); uart_we = 1'b0;
        wait_idle("post_rst_idle");
        chk("post_rst_frames", m_frames, fr + 1);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
